// File: rtl/frame_rd_burst_gen_pkg.sv
// -----------------------------------------------------------------------------
// frame_rd_burst_gen_pkg
//   Shared definitions for the frame-buffer read engine. The sensor-side write
//   generator uses the same definitions.
//   - rd_state_t   : FSM state encoding (IDLE / ISSUE / DONE)
//   - DEF_*        : default frame geometry and bus widths, so that the read
//                    and write paths agree on the frame layout
//   - burst_len()  : length of the next burst, min(max_len, remaining)
// -----------------------------------------------------------------------------
package frame_rd_burst_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } rd_state_t;

   localparam int DEF_ADDR_BITS   = 25;
   localparam int DEF_LINE_WORDS  = 1920;
   localparam int DEF_LINES       = 1080;
   localparam int DEF_LINE_STRIDE = 2048;
   localparam int DEF_BURST_LEN   = 64;
   localparam int DEF_LEN_BITS    = 7;

   // Words in the next burst: a full burst, or whatever is left of the line.
   function automatic int burst_len(input int remaining, input int max_len);
      return (remaining < max_len) ? remaining : max_len;
   endfunction

endpackage

// File: rtl/frame_rd_burst_gen_if.sv
// -----------------------------------------------------------------------------
// frame_rd_burst_gen_if
//   Burst read command channel toward the memory controller.
//   cmd_valid : command present (held until accepted)
//   cmd_ready : controller accepts when high together with cmd_valid
//   cmd_addr  : start word address of the burst
//   cmd_len   : words in the burst, 1..BURST_LEN
//   Modports: master (the engine) drives the command; slave (the controller)
//   drives ready.
// -----------------------------------------------------------------------------
interface frame_rd_burst_gen_if
   import frame_rd_burst_gen_pkg::*;
#(
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int LEN_BITS  = DEF_LEN_BITS
) ();

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [ADDR_BITS-1:0] cmd_addr;
   logic [LEN_BITS-1:0]  cmd_len;

   modport master (
      output cmd_valid,
      output cmd_addr,
      output cmd_len,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_addr,
      input  cmd_len,
      output cmd_ready
   );

endinterface

// File: rtl/frame_rd_burst_gen_vs_edge_det.sv
// -----------------------------------------------------------------------------
// rd_vs_edge_det
//   Registered rising-edge detector for a frame sync that is already synchronous
//   to clk. The delayed copy is registered and the edge is decoded
//   combinationally, so rise is high in the first cycle din is seen high.
//   Ports:
//     clk  : clock
//     rst  : asynchronous, active-high reset (delayed copy cleared)
//     din  : level input (frame sync)
//     rise : din & ~din_delayed
// -----------------------------------------------------------------------------
module rd_vs_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic din_d;

   // NOTE: state is written with non-blocking assignments so every register
   // samples pre-edge values, independent of the order of the always blocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) din_d <= 1'b0;
      else     din_d <= din;
   end

   assign rise = din & ~din_d;

endmodule

// File: rtl/frame_rd_burst_gen.sv
// -----------------------------------------------------------------------------
// frame_rd_burst_gen
//   Read-side frame fetch engine for the scaler path. A rising edge of
//   scaler_vs (while enabled) latches frame_base. The engine then walks the
//   frame line by line and issues burst read commands of at most BURST_LEN
//   words. Line starts advance by LINE_STRIDE through an accumulator. All
//   addresses wrap modulo 2^ADDR_BITS.
//   Ports:
//     scaler_clk  : sole clock
//     scaler_rst  : asynchronous, active-high reset
//     enable      : when low, no new frame starts. If it drops during a frame,
//                   the frame is abandoned once the pending command is accepted.
//     scaler_vs   : frame sync; a rising edge starts a frame
//     frame_base  : frame start address, sampled on the vs edge
//     cmd         : burst command channel (master side)
//     frame_busy  : high from frame start until the DONE cycle inclusive
//     frame_done  : one-cycle pulse after the last command of a frame is accepted
//     vs_overrun  : one-cycle pulse when a vs edge arrives mid-frame
// -----------------------------------------------------------------------------
module frame_rd_burst_gen
   import frame_rd_burst_gen_pkg::*;
#(
   parameter int ADDR_BITS   = DEF_ADDR_BITS,
   parameter int LINE_WORDS  = DEF_LINE_WORDS,
   parameter int LINES       = DEF_LINES,
   parameter int LINE_STRIDE = DEF_LINE_STRIDE,
   parameter int BURST_LEN   = DEF_BURST_LEN,
   parameter int LEN_BITS    = DEF_LEN_BITS
) (
   input  logic                  scaler_clk,
   input  logic                  scaler_rst,
   input  logic                  enable,
   input  logic                  scaler_vs,
   input  logic [ADDR_BITS-1:0]  frame_base,
   frame_rd_burst_gen_if.master  cmd,
   output logic                  frame_busy,
   output logic                  frame_done,
   output logic                  vs_overrun
);

   localparam int WC_BITS = $clog2(LINE_WORDS + 1);
   localparam int LC_BITS = $clog2(LINES + 1);

   rd_state_t            state;
   logic [ADDR_BITS-1:0] line_addr;   // start address of the current line
   logic [WC_BITS-1:0]   word_cnt;    // words of the current line already issued
   logic [LC_BITS-1:0]   line_cnt;    // lines of the frame already completed

   logic                 vs_rise;
   logic                 frame_start;
   logic                 handshake;
   logic [31:0]          wc_sum;
   logic                 line_end;
   logic                 last_line;
   logic [ADDR_BITS-1:0] next_line_addr;
   logic [LEN_BITS-1:0]  first_len;
   logic [LEN_BITS-1:0]  rem_len;

   rd_vs_edge_det u_vs_edge (
      .clk  (scaler_clk),
      .rst  (scaler_rst),
      .din  (scaler_vs),
      .rise (vs_rise)
   );

   // A new frame may start from IDLE or straight from DONE, so an edge that
   // coincides with the frame_done cycle is not lost.
   assign frame_start    = vs_rise & enable & (state != ST_ISSUE);
   assign handshake      = cmd.cmd_valid & cmd.cmd_ready;

   // cmd_addr doubles as the running word address within the line.
   assign wc_sum         = 32'(word_cnt) + 32'(cmd.cmd_len);
   assign line_end       = (wc_sum == 32'(LINE_WORDS));
   assign last_line      = (line_cnt == LC_BITS'(LINES - 1));
   assign next_line_addr = line_addr + ADDR_BITS'(LINE_STRIDE);
   assign first_len      = LEN_BITS'(burst_len(LINE_WORDS, BURST_LEN));
   assign rem_len        = LEN_BITS'(burst_len(LINE_WORDS - int'(wc_sum), BURST_LEN));

   always_ff @(posedge scaler_clk or posedge scaler_rst) begin
      if (scaler_rst) begin
         state         <= ST_IDLE;
         line_addr     <= '0;
         word_cnt      <= '0;
         line_cnt      <= '0;
         cmd.cmd_valid <= 1'b0;
         cmd.cmd_addr  <= '0;
         cmd.cmd_len   <= '0;
         frame_busy    <= 1'b0;
         frame_done    <= 1'b0;
         vs_overrun    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         vs_overrun <= 1'b0;

         if (frame_start) begin
            state         <= ST_ISSUE;
            line_addr     <= frame_base;
            word_cnt      <= '0;
            line_cnt      <= '0;
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_addr  <= frame_base;
            cmd.cmd_len   <= first_len;
            frame_busy    <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: ;

               ST_ISSUE: begin
                  // Mid-frame edges are reported and dropped.
                  if (vs_rise) vs_overrun <= 1'b1;

                  // A stalled command keeps addr/len; it never retracts, even
                  // if enable drops. The abort takes effect at the handshake.
                  if (handshake) begin
                     if (!enable) begin
                        state         <= ST_IDLE;
                        cmd.cmd_valid <= 1'b0;
                        frame_busy    <= 1'b0;
                     end else if (line_end) begin
                        word_cnt  <= '0;
                        line_cnt  <= line_cnt + 1'b1;
                        line_addr <= next_line_addr;
                        if (last_line) begin
                           state         <= ST_DONE;
                           cmd.cmd_valid <= 1'b0;
                           frame_done    <= 1'b1;
                        end else begin
                           cmd.cmd_addr <= next_line_addr;
                           cmd.cmd_len  <= first_len;
                        end
                     end else begin
                        word_cnt     <= WC_BITS'(wc_sum);
                        cmd.cmd_addr <= cmd.cmd_addr + ADDR_BITS'(cmd.cmd_len);
                        cmd.cmd_len  <= rem_len;
                     end
                  end
               end

               ST_DONE: begin
                  state      <= ST_IDLE;
                  frame_busy <= 1'b0;
               end

               default: begin
                  state         <= ST_IDLE;
                  cmd.cmd_valid <= 1'b0;
                  frame_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
